// File: rtl/key_io_dev_pkg.sv
// Shared register offsets and control-bit positions
// for the push-button key I/O responder.
package key_io_pkg;

    localparam logic [31:0] KDATA_OFS = 32'd0;
    localparam logic [31:0] KCTRL_OFS = 32'd4;

    localparam int CTRL_READY = 0;
    localparam int CTRL_OVR   = 1;
    localparam int CTRL_IE    = 8;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic ready;
    } kctrl_t;

    function automatic logic [8:0] ctrl_word(input kctrl_t c);
        logic [8:0] w;
        w = '0;
        w[CTRL_READY] = c.ready;
        w[CTRL_OVR]   = c.ovr;
        w[CTRL_IE]    = c.ie;
        return w;
    endfunction

endpackage

// File: rtl/key_io_dev_if.sv
// MEM-stage data bus as seen by the key I/O responder.
// The pipeline is the master, the device is the slave.
interface key_io_dev_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] abus;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic             re;
    logic [DBITS-1:0] rdata;
    logic             sel;

    modport master (
        output abus, wdata, we, re,
        input  rdata, sel
    );

    modport slave (
        input  abus, wdata, we, re,
        output rdata, sel
    );
endinterface

// File: rtl/key_io_dev_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for
// active-low keys; chg pulses in the cycle deb takes a new value.
module key_debounce #(
    parameter int KEYBITS   = 4,
    parameter int DEBCYCLES = 50000,
    parameter int DEBBITS   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEYBITS-1:0] key_n,
    output logic [KEYBITS-1:0] deb,
    output logic               chg
);

    localparam logic [DEBBITS-1:0] CNT_MAX = DEBBITS'(DEBCYCLES - 1);

    // sync flops hold raw active-low levels so reset means released
    logic [KEYBITS-1:0] s1_q, s1_d;
    logic [KEYBITS-1:0] s2_q, s2_d;
    logic [KEYBITS-1:0] cand_q, cand_d;
    logic [KEYBITS-1:0] deb_q, deb_d;
    logic [DEBBITS-1:0] cnt_q, cnt_d;
    logic [KEYBITS-1:0] p;
    logic               chg_w;

    always_comb begin
        s1_d   = key_n;
        s2_d   = s1_q;
        p      = ~s2_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        chg_w  = 1'b0;
        if (p != cand_q) begin
            cand_d = p;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            if (cand_q != deb_q) begin
                deb_d = cand_q;
                chg_w = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '1;
            s2_q   <= '1;
            cand_q <= '0;
            cnt_q  <= '0;
            deb_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign deb = deb_q;
    assign chg = chg_w;

endmodule

// File: rtl/key_io_dev.sv
// Memory-mapped key responder: KDATA/KCTRL decode, sticky
// Ready/Overrun/IE status and the registered interrupt line.
module key_io_dev
    import key_io_pkg::*;
#(
    parameter int               DBITS     = 32,
    parameter int               KEYBITS   = 4,
    parameter logic [DBITS-1:0] BASEADDR  = 32'hFFFFF080,
    parameter int               DEBCYCLES = 50000,
    parameter int               DEBBITS   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEYBITS-1:0] KEY_N,
    key_io_dev_if.slave        bus,
    output logic               intr
);

    localparam logic [DBITS-1:0] KDATA_ADDR = BASEADDR + DBITS'(KDATA_OFS);
    localparam logic [DBITS-1:0] KCTRL_ADDR = BASEADDR + DBITS'(KCTRL_OFS);

    logic [KEYBITS-1:0] deb;
    logic               chg;

    key_debounce #(
        .KEYBITS   (KEYBITS),
        .DEBCYCLES (DEBCYCLES),
        .DEBBITS   (DEBBITS)
    ) u_deb (
        .clk   (clk),
        .reset (reset),
        .key_n (KEY_N),
        .deb   (deb),
        .chg   (chg)
    );

    logic ready_q, ready_d;
    logic ovr_q, ovr_d;
    logic ie_q, ie_d;
    logic intr_q, intr_d;

    logic             hit_data;
    logic             hit_ctrl;
    logic             ctrl_wr;
    logic             clr;
    logic             ovr_clr;
    kctrl_t           ctrl;
    logic [DBITS-1:0] rdata;

    always_comb begin
        hit_data = (bus.abus == KDATA_ADDR);
        hit_ctrl = (bus.abus == KCTRL_ADDR);
        ctrl_wr  = bus.we && hit_ctrl;
        clr      = (bus.re && hit_data)
                 || (ctrl_wr && !bus.wdata[CTRL_READY]);
        ovr_clr  = ctrl_wr && !bus.wdata[CTRL_OVR];
        // a new debounced value beats a same-cycle clear
        ready_d  = chg | (ready_q & ~clr);
        ovr_d    = (chg & ready_q & ~clr) | (ovr_q & ~ovr_clr);
        ie_d     = ctrl_wr ? bus.wdata[CTRL_IE] : ie_q;
        intr_d   = ready_d & ie_d;
    end

    always_comb begin
        ctrl.ready = ready_q;
        ctrl.ovr   = ovr_q;
        ctrl.ie    = ie_q;
        rdata      = '0;
        if (bus.re) begin
            unique case (1'b1)
                hit_data: rdata = DBITS'(deb);
                hit_ctrl: rdata = DBITS'(ctrl_word(ctrl));
                default:  rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
            intr_q  <= intr_d;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^{bus.wdata[DBITS-1:CTRL_IE+1],
                            bus.wdata[CTRL_IE-1:CTRL_OVR+1]};

    assign bus.rdata = rdata;
    assign bus.sel   = hit_data | hit_ctrl;
    assign intr      = intr_q;

endmodule

// File: tb/tb_key_io_dev.sv
// Randomized and directed bench for key_io_dev with a
// sample-history reference model of the debouncer.
module tb_key_io_dev;

    localparam int          DEBC = 4;
    localparam logic [31:0] BASE = 32'hFFFFF080;
    localparam logic [31:0] KDAT = BASE;
    localparam logic [31:0] KCTL = BASE + 32'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic       intr;

    key_io_dev_if #(.DBITS(32)) bus ();

    key_io_dev #(
        .DBITS     (32),
        .KEYBITS   (4),
        .BASEADDR  (BASE),
        .DEBCYCLES (DEBC),
        .DEBBITS   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .KEY_N (key_n),
        .bus   (bus),
        .intr  (intr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: last DEBC+2 pressed-key samples taken by the first sync flop
    logic [3:0]  hist [0:DEBC+1];
    logic [3:0]  m_deb;
    logic        m_rdy, m_ovr, m_ie, m_intr;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= DEBC + 1; i++) hist[i] = 4'h0;
        m_deb  = 4'h0;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        m_ie   = 1'b0;
        m_intr = 1'b0;
    endtask

    // one bus cycle, entered and left at the falling edge
    task automatic cyc(input logic [3:0] kn, input logic [31:0] a,
                       input logic [31:0] wd, input logic w,
                       input logic r);
        logic        hd, hc, chg, stable, clr, oclr, n_ovr;
        logic [31:0] exp_rd;
        key_n     = kn;
        bus.abus  = a;
        bus.wdata = wd;
        bus.we    = w;
        bus.re    = r;
        #1;
        hd = (a == KDAT);
        hc = (a == KCTL);
        exp_rd = 32'h0;
        if (r && hd) exp_rd = {28'h0, m_deb};
        if (r && hc) exp_rd = {23'h0, m_ie, 6'h0, m_ovr, m_rdy};
        last_rd = bus.rdata;
        chk("sel", {31'h0, bus.sel}, {31'h0, hd | hc});
        chk("rdata", bus.rdata, exp_rd);
        @(posedge clk);
        stable = 1'b1;
        for (int i = 2; i <= DEBC + 1; i++)
            if (hist[i] != hist[1]) stable = 1'b0;
        chg = stable && (hist[1] != m_deb);
        if (chg) m_deb = hist[1];
        for (int i = DEBC + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = ~kn;
        clr  = (r && hd) || (w && hc && !wd[0]);
        oclr = w && hc && !wd[1];
        n_ovr = (chg && m_rdy && !clr) || (m_ovr && !oclr);
        m_rdy = chg || (m_rdy && !clr);
        m_ovr = n_ovr;
        if (w && hc) m_ie = wd[8];
        m_intr = m_rdy && m_ie;
        #1;
        chk("intr", {31'h0, intr}, {31'h0, m_intr});
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_addr();
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0, 1:    return KDAT;
            2, 3:    return KCTL;
            4:       return BASE + 32'd8;
            default: return BASE + 32'($urandom_range(1, 3));
        endcase
    endfunction

    initial begin
        logic [3:0] kcur;
        int         hold;
        reset     = 1'b0;
        key_n     = 4'hF;
        bus.abus  = 32'h0;
        bus.wdata = 32'h0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        bus.abus = KDAT;
        bus.re   = 1'b1;
        #1;
        chk("rst_kdata", bus.rdata, 32'h0);
        chk("rst_intr", {31'h0, intr}, 32'h0);
        bus.abus = KCTL;
        #1;
        chk("rst_kctrl", bus.rdata, 32'h0);
        bus.re = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        cyc(4'hF, KDAT, 0, 0, 1);
        cyc(4'hF, KCTL, 0, 0, 1);
        repeat (20) cyc(4'hF, KCTL, 0, 0, 1);
        chk("idle_ready", last_rd, 32'h0);

        // press key0 with IE on: Ready lands exactly six edges later
        cyc(4'hF, KCTL, 32'h101, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(4'hE, KCTL, 0, 0, 1);
            if (i == 6) chk("press_early", last_rd & 32'h1, 32'h0);
            if (i == 6) chk("press_intr", {31'h0, intr}, 32'h1);
            if (i == 7) chk("press_lat", last_rd & 32'h1, 32'h1);
        end
        cyc(4'hE, KDAT, 0, 0, 1);
        chk("press_deb", last_rd, 32'h1);

        repeat (8) cyc(4'hF, 32'h0, 0, 0, 0);
        cyc(4'hF, KDAT, 0, 0, 1);
        chk("release_deb", last_rd, 32'h0);
        repeat (3) cyc(4'hB, 32'h0, 0, 0, 0);
        repeat (10) cyc(4'hF, KCTL, 0, 0, 1);
        chk("glitch_ctrl", last_rd, 32'h100);
        cyc(4'hF, KDAT, 0, 0, 1);
        chk("glitch_deb", last_rd, 32'h0);

        repeat (8) cyc(4'hE, 32'h0, 0, 0, 0);
        repeat (8) cyc(4'hC, 32'h0, 0, 0, 0);
        cyc(4'hC, KCTL, 0, 0, 1);
        chk("ovr_ctrl", last_rd, 32'h103);
        cyc(4'hC, KDAT, 0, 0, 1);
        chk("ovr_kdata", last_rd, 32'h3);
        cyc(4'hC, KCTL, 0, 0, 1);
        chk("ovr_after_rd", last_rd, 32'h102);
        cyc(4'hC, KCTL, 32'h100, 1, 0);
        cyc(4'hC, KCTL, 0, 0, 1);
        chk("ovr_cleared", last_rd, 32'h100);

        // KDATA read lands in the cycle the release is accepted
        for (int i = 0; i < 8; i++) begin
            if (i == 6) cyc(4'hF, KDAT, 0, 0, 1);
            else        cyc(4'hF, KCTL, 0, 0, 1);
            if (i == 6) chk("coll_old_deb", last_rd, 32'h3);
            if (i == 7) chk("coll_ctrl", last_rd, 32'h101);
        end

        cyc(4'hF, BASE + 32'd8, 32'h0, 1, 1);
        chk("dec_p8", last_rd, 32'h0);
        cyc(4'hF, BASE - 32'd4, 32'h0, 1, 1);
        chk("dec_m4", last_rd, 32'h0);
        cyc(4'hF, BASE + 32'd1, 32'h0, 1, 1);
        chk("dec_p1", last_rd, 32'h0);
        cyc(4'hF, KCTL, 0, 0, 1);
        chk("dec_nochg", last_rd, 32'h101);

        kcur = 4'hF;
        hold = 0;
        for (int n = 0; n < 800; n++) begin
            int          op;
            logic [31:0] wd;
            if (hold == 0) begin
                kcur = 4'($urandom);
                hold = $urandom_range(1, 10);
            end
            hold--;
            op = $urandom_range(0, 7);
            wd = $urandom;
            case (op)
                0:       cyc(kcur, 32'h0, wd, 0, 0);
                1:       cyc(kcur, KDAT, wd, 0, 1);
                2, 3:    cyc(kcur, KCTL, wd, 0, 1);
                4:       cyc(kcur, KCTL, wd | 32'h3, 1, 0);
                5:       cyc(kcur, KCTL, wd, 1, $urandom_range(0, 1) == 1);
                6:       cyc(kcur, KDAT, wd, 1, 1);
                default: cyc(kcur, rnd_addr(), wd, 1, 1);
            endcase
        end

        cyc(4'hF, KCTL, 32'h100, 1, 0);
        repeat (8) cyc(4'hE, 32'h0, 0, 0, 0);
        repeat (3) cyc(4'hD, 32'h0, 0, 0, 0);
        key_n    = 4'hD;
        bus.abus = KDAT;
        bus.we   = 1'b0;
        bus.re   = 1'b1;
        #1 chk("arst_pre_deb", bus.rdata, 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_deb", bus.rdata, 32'h0);
        chk("arst_intr", {31'h0, intr}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(4'hD, KCTL, 0, 0, 1);
            if (i == 6) chk("arst_early", last_rd, 32'h0);
            if (i == 7) chk("arst_press", last_rd, 32'h1);
        end
        cyc(4'hD, KDAT, 0, 0, 1);
        chk("arst_deb_new", last_rd, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
